// File: rtl/frame_timer_bank.sv
// Bank of NUM_CH independent frame-count timers with one-shot/periodic modes,
// retrigger, cancel and a global pause; all outputs registered except any_expired.
module frame_timer_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       start_req,
    input  logic [NUM_CH-1:0]       cancel_req,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] load_value,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired,
    output logic [NUM_CH*CNT_W-1:0] remaining,
    output logic                    any_expired
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Requests are single-cycle strobes with no ready: every asserted bit is
    // acted on at the next edge, with cancel_req winning over start_req.
    logic frame_tick;
    assign frame_tick = startOfFrame && !pause;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [CNT_W-1:0] reload_q, reload_d;
        logic             mode_q, mode_d;
        logic             exp_q, exp_d;
        logic [CNT_W-1:0] ld;

        assign ld = load_value[i*CNT_W +: CNT_W];

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                state_q  <= IDLE;
                count_q  <= '0;
                reload_q <= '0;
                mode_q   <= 1'b0;
                exp_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                count_q  <= count_d;
                reload_q <= reload_d;
                mode_q   <= mode_d;
                exp_q    <= exp_d;
            end
        end

        always_comb begin
            state_d  = state_q;
            count_d  = count_q;
            reload_d = reload_q;
            mode_d   = mode_q;
            exp_d    = 1'b0;
            if (cancel_req[i]) begin
                if (state_q == RUN) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end else if (start_req[i]) begin
                // A zero load expires at once and never enters RUN.
                if (ld != '0) begin
                    state_d  = RUN;
                    count_d  = ld;
                    reload_d = ld;
                    mode_d   = periodic[i];
                end else begin
                    state_d = IDLE;
                    count_d = '0;
                    exp_d   = 1'b1;
                end
            end else if (frame_tick && state_q == RUN) begin
                if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    exp_d = 1'b1;
                    if (mode_q) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
            end
        end

        assign busy[i]                     = (state_q == RUN);
        assign expired[i]                  = exp_q;
        assign remaining[i*CNT_W +: CNT_W] = count_q;
    end

    assign any_expired = |expired;

endmodule

// File: tb/tb_frame_timer_bank.sv
// Directed self-checking bench for frame_timer_bank (NUM_CH=4, CNT_W=8).
module tb_frame_timer_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    resetN = 1'b0;
    logic                    startOfFrame = 1'b0;
    logic                    pause = 1'b0;
    logic [NUM_CH-1:0]       start_req = '0;
    logic [NUM_CH-1:0]       cancel_req = '0;
    logic [NUM_CH-1:0]       periodic = '0;
    logic [NUM_CH*CNT_W-1:0] load_value = '0;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       expired;
    logic [NUM_CH*CNT_W-1:0] remaining;
    logic                    any_expired;

    int n_assert = 0;
    int n_fail   = 0;

    frame_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pause(pause),
        .start_req(start_req), .cancel_req(cancel_req), .periodic(periodic),
        .load_value(load_value), .busy(busy), .expired(expired),
        .remaining(remaining), .any_expired(any_expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rem(input int ch);
        return 32'(remaining[ch*CNT_W +: CNT_W]);
    endfunction

    // Advance to just after the next rising edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Nine quiet cycles, then a frame tick sampled at the following edge.
    task automatic tick();
        step(9);
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic start(input int ch, input int val, input logic per, input logic sof = 1'b0);
        load_value[ch*CNT_W +: CNT_W] = CNT_W'(val);
        periodic[ch]   = per;
        start_req[ch]  = 1'b1;
        startOfFrame   = sof;
        step();
        start_req[ch]  = 1'b0;
        startOfFrame   = 1'b0;
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_any", 32'(any_expired), 0);
        resetN = 1'b1;
        step(2);

        // One-shot ch0, load 3
        start(0, 3, 1'b0);
        chk("os_busy", 32'(busy[0]), 1);
        chk("os_rem_load", rem(0), 3);
        tick();
        chk("os_rem_t1", rem(0), 2);
        tick();
        chk("os_rem_t2", rem(0), 1);
        chk("os_noexp_t2", 32'(expired[0]), 0);
        tick();
        chk("os_exp", 32'(expired), 4'b0001);
        chk("os_any", 32'(any_expired), 1);
        chk("os_rem_end", rem(0), 0);
        chk("os_busy_end", 32'(busy[0]), 0);
        step();
        chk("os_exp_clear", 32'(expired[0]), 0);

        // Periodic ch1, load 2, seven ticks
        start(1, 2, 1'b1);
        chk("per_rem_load", rem(1), 2);
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk($sformatf("per_exp_t%0d", t), 32'(expired[1]), (t % 2 == 0) ? 1 : 0);
            chk($sformatf("per_rem_t%0d", t), rem(1), (t % 2 == 0) ? 2 : 1);
            chk($sformatf("per_busy_t%0d", t), 32'(busy[1]), 1);
        end
        cancel_req[1] = 1'b1;
        step();
        cancel_req[1] = 1'b0;
        chk("per_cancel_busy", 32'(busy[1]), 0);
        chk("per_cancel_exp", 32'(expired[1]), 0);
        chk("per_cancel_rem", rem(1), 0);
        step();
        chk("per_cancel_exp2", 32'(expired[1]), 0);

        // Zero load ch2, periodic 1
        start(2, 0, 1'b1);
        chk("zero_exp", 32'(expired), 4'b0100);
        chk("zero_busy", 32'(busy[2]), 0);
        step();
        chk("zero_exp_clear", 32'(expired[2]), 0);
        chk("zero_busy2", 32'(busy[2]), 0);

        // Retrigger on ch3
        start(3, 5, 1'b0);
        tick();
        tick();
        chk("rt_rem_before", rem(3), 3);
        start(3, 4, 1'b0);
        chk("rt_rem_reload", rem(3), 4);
        tick(); tick(); tick();
        chk("rt_rem_1", rem(3), 1);
        chk("rt_noexp", 32'(expired[3]), 0);
        tick();
        chk("rt_exp", 32'(expired), 4'b1000);
        chk("rt_busy_end", 32'(busy[3]), 0);

        // Cancel and start together: cancel wins
        start(3, 5, 1'b0);
        load_value[3*CNT_W +: CNT_W] = 8'd7;
        start_req[3]  = 1'b1;
        cancel_req[3] = 1'b1;
        step();
        start_req[3]  = 1'b0;
        cancel_req[3] = 1'b0;
        chk("cs_busy", 32'(busy[3]), 0);
        chk("cs_rem", rem(3), 0);
        chk("cs_exp", 32'(expired[3]), 0);
        step();
        chk("cs_exp2", 32'(expired[3]), 0);

        // Start coinciding with a frame tick, from IDLE and as retrigger
        start(3, 6, 1'b0, 1'b1);
        chk("sof_idle_rem", rem(3), 6);
        start(3, 9, 1'b0, 1'b1);
        chk("sof_run_rem", rem(3), 9);
        cancel_req[3] = 1'b1;
        step();
        cancel_req[3] = 1'b0;

        // Pause swallows ticks
        start(0, 2, 1'b0);
        pause = 1'b1;
        tick(); tick(); tick();
        chk("pause_rem", rem(0), 2);
        chk("pause_exp", 32'(expired[0]), 0);
        pause = 1'b0;
        tick();
        chk("pause_rem_after", rem(0), 1);
        tick();
        chk("pause_exp_after", 32'(expired[0]), 1);
        chk("pause_rem_end", rem(0), 0);

        // Asynchronous reset mid-run
        start(0, 10, 1'b0);
        start(1, 10, 1'b1);
        tick();
        chk("mr_rem0", rem(0), 9);
        chk("mr_busy", 32'(busy), 4'b0011);
        #2 resetN = 1'b0;
        #1;
        chk("mr_busy_rst", 32'(busy), 0);
        chk("mr_rem_rst", remaining, 0);
        chk("mr_exp_rst", 32'(expired), 0);
        step(2);
        resetN = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk($sformatf("mr_noexp_t%0d", t), 32'(expired), 0);
        end
        chk("mr_busy_after", 32'(busy), 0);

        // Two channels expiring together
        load_value[0 +: CNT_W]     = 8'd1;
        load_value[CNT_W +: CNT_W] = 8'd1;
        periodic   = '0;
        start_req  = 4'b0011;
        step();
        start_req  = '0;
        chk("mc_busy", 32'(busy), 4'b0011);
        tick();
        chk("mc_exp", 32'(expired), 4'b0011);
        chk("mc_any", 32'(any_expired), 1);
        step();
        chk("mc_exp_clear", 32'(expired), 0);
        chk("mc_any_clear", 32'(any_expired), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_timer_bank.md
# frame_timer_bank

Bank of NUM_CH independent frame-based countdown timers for the game logic. Each channel is loaded with a frame count, decrements once per startOfFrame, and emits a one-cycle expired pulse when the count runs out. Channels support one-shot or periodic (auto-reload) mode, retrigger, cancel and a global pause. The block serves as the shared timing resource for game events such as spell cooldowns, blink timers and level countdowns.

## Interface
- NUM_CH, 4, number of independent timer channels (1..16)
- CNT_W, 8, width of frame count per channel
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle frame tick, shared by all channels
- pause  in  1  level; while high, frame ticks are ignored by all channels
- start_req  in  NUM_CH  per-channel load/retrigger request, one-cycle
- cancel_req  in  NUM_CH  per-channel abort request, one-cycle
- periodic  in  NUM_CH  mode sampled with start_req: 1 = auto-reload, 0 = one-shot
- load_value  in  NUM_CH*CNT_W  channel i count in bits [i*CNT_W +: CNT_W], sampled with start_req[i]
- busy  out  NUM_CH  channel i is running
- expired  out  NUM_CH  one-cycle pulse per channel expiry
- remaining  out  NUM_CH*CNT_W  frames left per channel, same packing as load_value
- any_expired  out  1  OR of expired

## Operation
- Per-channel state: IDLE, RUN. Per-channel registers: count, reload value, mode bit.
- Per-channel event priority: cancel_req > start_req > frame tick.
- Frame tick = startOfFrame && !pause.
- IDLE:
  - start_req, load_value != 0: count and reload <= load_value, mode <= periodic[i], go to RUN.
  - start_req, load_value == 0: expired pulses immediately (next cycle); stay IDLE regardless of mode.
  - A frame tick has no effect.
- RUN:
  - cancel_req: go to IDLE, count <= 0, no expired pulse.
  - start_req (retrigger): reload count, reload value and mode from inputs, as in IDLE. A load_value of 0 gives an expired pulse and returns to IDLE.
  - Frame tick, count > 1: count <= count - 1.
  - Frame tick, count == 1: expired pulse.
    - Periodic: count <= reload value, stay in RUN.
    - One-shot: count <= 0, go to IDLE.
- cancel_req in IDLE: no effect.
- Channels are fully independent. Simultaneous expiries on several channels each pulse their own bit; any_expired is high for that one cycle.
- Arithmetic: count is unsigned CNT_W. It never wraps, because decrement only occurs for count > 1. The maximum period is 2^CNT_W - 1 frames.
- busy = (state == RUN). remaining = count.

## Timing
- Reset (resetN low, asynchronous): all channels go to IDLE.
  - count, reload value and mode are cleared.
  - busy, expired, remaining and any_expired are all 0.
  - Any in-flight timer is discarded and no pulse is generated.
- All outputs are registered, except any_expired, which is combinational OR of the registered expired.
- start_req sampled at edge k:
  - busy = 1 and remaining = load_value from cycle k+1.
- A tick that coincides with start_req is consumed by the load and does not decrement.
- The N-th subsequent frame tick is sampled at edge m. expired is high for exactly cycle m+1, with remaining = 0 (one-shot) or the reload value (periodic).
- Zero-load start at edge k: expired is high in cycle k+1 only.
- Periodic mode: successive expired pulses are exactly N frame ticks apart.
- pause high across a startOfFrame: that tick is lost, not deferred.
- expired never stays high for 2 consecutive cycles on the same channel, except for retrigger-with-zero on back-to-back cycles.

## Test plan
- One-shot, ch0, load 3, periodic 0, ticks every 10 cycles -> remaining 3,2,1. expired[0] pulses once, 1 cycle after the 3rd tick, then busy[0] = 0 and remaining = 0.
- Periodic, ch1, load 2, 7 ticks -> expired[1] after ticks 2, 4 and 6. remaining reloads to 2 each time. busy stays 1 until cancel_req[1], which gives busy = 0 with no pulse.
- Zero load, ch2, start with load 0, periodic 1 -> expired[2] high for 1 cycle, then busy[2] stays 0.
- Retrigger and collisions on ch3, load 5:
  - After 2 ticks, start with load 4 -> remaining 4, and expiry occurs after 4 further ticks.
  - cancel_req and start_req in the same cycle -> IDLE, no expired.
  - start_req coinciding with startOfFrame -> remaining equals load_value.
- Pause: ch0 load 2, pause high over 3 ticks -> remaining holds at 2. After release, expiry follows 2 more ticks.
- Reset mid-run and multi-channel: resetN pulsed low while ch0 and ch1 are busy -> all outputs 0 immediately, no pulse after release. Then ch0 and ch1 both loaded with 1 on the same tick -> expired = 4'b0011 and any_expired = 1 for one cycle.
